imm_enc: RTL

IMM_ENC -- requirements
Module: imm_enc

---
 rtl/imm_enc.sv | 107 ++++++++++
 1 files changed

// File: rtl/imm_enc.sv
// Immediate encoder: turns a 32-bit constant into one or two {eop, imm16} words
// for an immediate extender. Define IMM_ENC_STATS_EN to add the stat_in/stat_split counters.
module imm_enc (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [15:0] stat_in,
    output logic [15:0] stat_split
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ONE  = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] LO   = 2'd3;

    logic [1:0]  state;
    logic [15:0] lo_imm;
    logic        in_hs;
    logic        out_hs;
    logic        is_split;
    logic [1:0]  cls_eop;
    logic [15:0] cls_imm;

    assign out_valid = (state != IDLE);
    assign out_hs    = out_valid && out_ready;
    // A new constant is taken only once the final word of the previous one leaves.
    assign in_ready  = !reset && ((state == IDLE) || (out_hs && out_last));
    assign in_hs     = in_valid && in_ready;

    // Classification in priority order; a split constant first sends its upper half.
    always_comb begin
        is_split = 1'b0;
        cls_eop  = 2'b00;
        cls_imm  = in_data[15:0];
        if ((&in_data[31:15]) || (~|in_data[31:15])) begin
            cls_eop = 2'b00;
            cls_imm = in_data[15:0];
        end else if (in_data[31:16] == 16'h0000) begin
            cls_eop = 2'b01;
            cls_imm = in_data[15:0];
        end else if (in_data[15:0] == 16'h0000) begin
            cls_eop = 2'b10;
            cls_imm = in_data[31:16];
        end else if ((in_data[1:0] == 2'b00) &&
                     ((&in_data[31:17]) || (~|in_data[31:17]))) begin
            cls_eop = 2'b11;
            cls_imm = in_data[17:2];
        end else begin
            is_split = 1'b1;
            cls_eop  = 2'b10;
            cls_imm  = in_data[31:16];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            out_imm  <= 16'h0000;
            out_eop  <= 2'b00;
            out_last <= 1'b0;
            lo_imm   <= 16'h0000;
        end else if (in_hs) begin
            state    <= is_split ? HI : ONE;
            out_eop  <= cls_eop;
            out_imm  <= cls_imm;
            out_last <= !is_split;
            lo_imm   <= in_data[15:0];
        end else if (out_hs) begin
            if (state == HI) begin
                state    <= LO;
                out_eop  <= 2'b01;
                out_imm  <= lo_imm;
                out_last <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

`ifdef IMM_ENC_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_in    <= 16'h0000;
            stat_split <= 16'h0000;
        end else if (in_hs) begin
            if (stat_in != 16'hFFFF) begin
                stat_in <= stat_in + 16'd1;
            end
            if (is_split && (stat_split != 16'hFFFF)) begin
                stat_split <= stat_split + 16'd1;
            end
        end
    end
`endif

endmodule
